cp0_tlb_regs: RTL and testbench

CP0-side register bank for the MMU: holds Index, Random, EntryLo0, EntryLo1, Context, PageMask, Wired and EntryHi, and is the CP0 end of the TLB-instruction interface. It supplies the register values the TLB array needs for TLBWI/TLBWR, lookups and TLBP. It captures TLBP and TLBR results returned by the TLB, and updates EntryHi/Context on TLB exceptions. It sits in the writeback/commit stage next to the main CP0 and serves MFC0/MTC0 for these eight registers.

---
 rtl/cp0_tlb_regs.sv | 214 +++++++++++++++++++++
 tb/tb_cp0_tlb_regs.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_tlb_regs.sv
// -----------------------------------------------------------------------------
// cp0_tlb_regs
//
// CP0-side register bank for the MMU. It holds Index, Random, EntryLo0,
// EntryLo1, Context, PageMask, Wired and EntryHi, and forms the CP0 end of the
// TLB-instruction interface. It serves MFC0/MTC0 for these eight registers,
// captures TLBP/TLBR results, and records the faulting VPN2 on TLB exceptions.
//
// Ports
//   clk_i                clock; all state changes on the rising edge
//   resetn_i             asynchronous active-low reset
//   mtc0_en_i            MTC0 commits this cycle
//   mtc0_addr_i/_sel_i   destination CP0 register number / select
//   mtc0_data_i          MTC0 write data
//   mfc0_addr_i/_sel_i   MFC0 source register number / select
//   mfc0_data_o          MFC0 read data (combinational from registers)
//   tlbp_en_i            TLBP commits this cycle
//   tlbr_en_i            TLBR commits this cycle
//   tlb_index_in_i       TLB probe result (bit31 = miss, low bits = hit index)
//   tlb_*_in_i           TLB entry read data for TLBR
//   tlb_exc_i            committed TLB refill/invalid/modify exception
//   exc_badvaddr_i       faulting virtual address
//   entryhi_o ... context_o  registered CP0 values for the TLB and exception logic
// -----------------------------------------------------------------------------
module cp0_tlb_regs #(
  parameter int TLB_LINE_NUM      = 8,
  parameter int LOG2_TLB_LINE_NUM = 3
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        mtc0_en_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [2:0]  mtc0_sel_i,
  input  logic [31:0] mtc0_data_i,
  input  logic [4:0]  mfc0_addr_i,
  input  logic [2:0]  mfc0_sel_i,
  output logic [31:0] mfc0_data_o,
  input  logic        tlbp_en_i,
  input  logic        tlbr_en_i,
  input  logic [31:0] tlb_index_in_i,
  input  logic [31:0] tlb_entryhi_in_i,
  input  logic [31:0] tlb_pagemask_in_i,
  input  logic [31:0] tlb_entrylo0_in_i,
  input  logic [31:0] tlb_entrylo1_in_i,
  input  logic        tlb_exc_i,
  input  logic [31:0] exc_badvaddr_i,
  output logic [31:0] entryhi_o,
  output logic [31:0] pagemask_o,
  output logic [31:0] entrylo0_o,
  output logic [31:0] entrylo1_o,
  output logic [31:0] index_o,
  output logic [31:0] random_o,
  output logic [31:0] context_o
);

  localparam logic [4:0] ADDR_INDEX    = 5'd0;
  localparam logic [4:0] ADDR_RANDOM   = 5'd1;
  localparam logic [4:0] ADDR_ENTRYLO0 = 5'd2;
  localparam logic [4:0] ADDR_ENTRYLO1 = 5'd3;
  localparam logic [4:0] ADDR_CONTEXT  = 5'd4;
  localparam logic [4:0] ADDR_PAGEMASK = 5'd5;
  localparam logic [4:0] ADDR_WIRED    = 5'd6;
  localparam logic [4:0] ADDR_ENTRYHI  = 5'd10;

  // Writable-field masks
  localparam logic [31:0] IDX_MASK      = 32'(TLB_LINE_NUM - 1);
  localparam logic [31:0] P_MASK        = 32'h8000_0000;
  localparam logic [31:0] ENTRYLO_MASK  = 32'h03FF_FFFF;
  localparam logic [31:0] PAGEMASK_MASK = 32'h01FF_E000;
  localparam logic [31:0] ENTRYHI_MASK  = 32'hFFFF_E0FF;
  localparam logic [31:0] VPN2_MASK     = 32'hFFFF_E000;
  localparam logic [31:0] ASID_MASK     = 32'h0000_00FF;
  localparam logic [31:0] PTEBASE_MASK  = 32'hFF80_0000;
  localparam logic [31:0] BADVPN2_MASK  = 32'h007F_FFF0;

  localparam logic [LOG2_TLB_LINE_NUM-1:0] RAND_TOP =
    LOG2_TLB_LINE_NUM'(TLB_LINE_NUM - 1);

  // State
  logic [31:0] index_q,    index_d;
  logic [31:0] entrylo0_q, entrylo0_d;
  logic [31:0] entrylo1_q, entrylo1_d;
  logic [31:0] context_q,  context_d;
  logic [31:0] pagemask_q, pagemask_d;
  logic [31:0] entryhi_q,  entryhi_d;
  logic [LOG2_TLB_LINE_NUM-1:0] wired_q,  wired_d;
  logic [LOG2_TLB_LINE_NUM-1:0] random_q, random_d;

  // MTC0 decode: only select 0 addresses the bank
  logic wr_sel0;
  logic wr_index, wr_entrylo0, wr_entrylo1, wr_context;
  logic wr_pagemask, wr_wired, wr_entryhi;

  always_comb begin
    wr_sel0     = mtc0_en_i && (mtc0_sel_i == 3'd0);
    wr_index    = wr_sel0 && (mtc0_addr_i == ADDR_INDEX);
    wr_entrylo0 = wr_sel0 && (mtc0_addr_i == ADDR_ENTRYLO0);
    wr_entrylo1 = wr_sel0 && (mtc0_addr_i == ADDR_ENTRYLO1);
    wr_context  = wr_sel0 && (mtc0_addr_i == ADDR_CONTEXT);
    wr_pagemask = wr_sel0 && (mtc0_addr_i == ADDR_PAGEMASK);
    wr_wired    = wr_sel0 && (mtc0_addr_i == ADDR_WIRED);
    wr_entryhi  = wr_sel0 && (mtc0_addr_i == ADDR_ENTRYHI);
  end

  // Next-state logic. Each register takes the highest-priority source that
  // targets it: exception > TLBR > TLBP > MTC0.
  always_comb begin
    index_d    = index_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    context_d  = context_q;
    pagemask_d = pagemask_q;
    entryhi_d  = entryhi_q;
    wired_d    = wired_q;
    random_d   = random_q;

    // Index: P bit is only ever set by a probe; MTC0 keeps the current P.
    if (tlbp_en_i) begin
      index_d = tlb_index_in_i & (P_MASK | IDX_MASK);
    end else if (wr_index) begin
      index_d = (index_q & P_MASK) | (mtc0_data_i & IDX_MASK);
    end

    if (tlbr_en_i) begin
      entrylo0_d = tlb_entrylo0_in_i & ENTRYLO_MASK;
      entrylo1_d = tlb_entrylo1_in_i & ENTRYLO_MASK;
      pagemask_d = tlb_pagemask_in_i & PAGEMASK_MASK;
    end else begin
      if (wr_entrylo0) entrylo0_d = mtc0_data_i & ENTRYLO_MASK;
      if (wr_entrylo1) entrylo1_d = mtc0_data_i & ENTRYLO_MASK;
      if (wr_pagemask) pagemask_d = mtc0_data_i & PAGEMASK_MASK;
    end

    // EntryHi: the TLB keeps G in bit 12, so the EntryHi mask strips it.
    if (tlb_exc_i) begin
      entryhi_d = (exc_badvaddr_i & VPN2_MASK) | (entryhi_q & ASID_MASK);
    end else if (tlbr_en_i) begin
      entryhi_d = tlb_entryhi_in_i & ENTRYHI_MASK;
    end else if (wr_entryhi) begin
      entryhi_d = mtc0_data_i & ENTRYHI_MASK;
    end

    // Context: BadVPN2 [22:4] is VA[31:13], i.e. the address shifted right by 9.
    if (tlb_exc_i) begin
      context_d = (context_q & PTEBASE_MASK) | ((exc_badvaddr_i >> 9) & BADVPN2_MASK);
    end else if (wr_context) begin
      context_d = (mtc0_data_i & PTEBASE_MASK) | (context_q & BADVPN2_MASK);
    end

    if (wr_wired) begin
      wired_d = LOG2_TLB_LINE_NUM'(mtc0_data_i & IDX_MASK);
    end

    // Random counts down from the top to Wired and wraps; a Wired write
    // restarts it at the top so it never falls below the new floor.
    if (wr_wired || (random_q == wired_q)) begin
      random_d = RAND_TOP;
    end else begin
      random_d = random_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      index_q    <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      context_q  <= '0;
      pagemask_q <= '0;
      entryhi_q  <= '0;
      wired_q    <= '0;
      random_q   <= RAND_TOP;
    end else begin
      index_q    <= index_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
      context_q  <= context_d;
      pagemask_q <= pagemask_d;
      entryhi_q  <= entryhi_d;
      wired_q    <= wired_d;
      random_q   <= random_d;
    end
  end

  // Register outputs
  always_comb begin
    index_o    = index_q;
    random_o   = 32'(random_q);
    entrylo0_o = entrylo0_q;
    entrylo1_o = entrylo1_q;
    context_o  = context_q;
    pagemask_o = pagemask_q;
    entryhi_o  = entryhi_q;
  end

  // MFC0 read mux; unmapped addresses and non-zero selects read 0
  always_comb begin
    mfc0_data_o = '0;
    if (mfc0_sel_i == 3'd0) begin
      case (mfc0_addr_i)
        ADDR_INDEX:    mfc0_data_o = index_q;
        ADDR_RANDOM:   mfc0_data_o = 32'(random_q);
        ADDR_ENTRYLO0: mfc0_data_o = entrylo0_q;
        ADDR_ENTRYLO1: mfc0_data_o = entrylo1_q;
        ADDR_CONTEXT:  mfc0_data_o = context_q;
        ADDR_PAGEMASK: mfc0_data_o = pagemask_q;
        ADDR_WIRED:    mfc0_data_o = 32'(wired_q);
        ADDR_ENTRYHI:  mfc0_data_o = entryhi_q;
        default:       mfc0_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_tlb_regs.sv
module tb_cp0_tlb_regs;

  logic        clk;
  logic        resetn;
  logic        mtc0_en;
  logic [4:0]  mtc0_addr;
  logic [2:0]  mtc0_sel;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [2:0]  mfc0_sel;
  logic [31:0] mfc0_data;
  logic        tlbp_en;
  logic        tlbr_en;
  logic [31:0] tlb_index_in;
  logic [31:0] tlb_entryhi_in;
  logic [31:0] tlb_pagemask_in;
  logic [31:0] tlb_entrylo0_in;
  logic [31:0] tlb_entrylo1_in;
  logic        tlb_exc;
  logic [31:0] exc_badvaddr;
  logic [31:0] entryhi, pagemask, entrylo0, entrylo1, index_r, random_r, context_r;

  int checks   = 0;
  int failures = 0;

  cp0_tlb_regs #(.TLB_LINE_NUM(8), .LOG2_TLB_LINE_NUM(3)) dut (
    .clk_i             (clk),
    .resetn_i          (resetn),
    .mtc0_en_i         (mtc0_en),
    .mtc0_addr_i       (mtc0_addr),
    .mtc0_sel_i        (mtc0_sel),
    .mtc0_data_i       (mtc0_data),
    .mfc0_addr_i       (mfc0_addr),
    .mfc0_sel_i        (mfc0_sel),
    .mfc0_data_o       (mfc0_data),
    .tlbp_en_i         (tlbp_en),
    .tlbr_en_i         (tlbr_en),
    .tlb_index_in_i    (tlb_index_in),
    .tlb_entryhi_in_i  (tlb_entryhi_in),
    .tlb_pagemask_in_i (tlb_pagemask_in),
    .tlb_entrylo0_in_i (tlb_entrylo0_in),
    .tlb_entrylo1_in_i (tlb_entrylo1_in),
    .tlb_exc_i         (tlb_exc),
    .exc_badvaddr_i    (exc_badvaddr),
    .entryhi_o         (entryhi),
    .pagemask_o        (pagemask),
    .entrylo0_o        (entrylo0),
    .entrylo1_o        (entrylo1),
    .index_o           (index_r),
    .random_o          (random_r),
    .context_o         (context_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        men;
    logic [4:0]  wa;
    logic [2:0]  ws;
    logic [31:0] wd;
    logic        tp;
    logic        tr;
    logic [31:0] tidx;
    logic [31:0] tehi;
    logic [31:0] tpm;
    logic [31:0] tlo0;
    logic [31:0] tlo1;
    logic        ex;
    logic [31:0] bva;
    logic [4:0]  ra;
    logic [2:0]  rs;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  ra;
    logic [2:0]  rs;
    logic [31:0] exp;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic men, input logic [4:0] wa,
                              input logic [2:0] ws, input logic [31:0] wd, input logic tp,
                              input logic tr, input logic [31:0] tidx, input logic [31:0] tehi,
                              input logic [31:0] tpm, input logic [31:0] tlo0,
                              input logic [31:0] tlo1, input logic ex, input logic [31:0] bva,
                              input logic [4:0] ra, input logic [2:0] rs, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.men = men; v.wa = wa; v.ws = ws; v.wd = wd;
    v.tp = tp; v.tr = tr; v.tidx = tidx; v.tehi = tehi; v.tpm = tpm;
    v.tlo0 = tlo0; v.tlo1 = tlo1; v.ex = ex; v.bva = bva;
    v.ra = ra; v.rs = rs; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Direct register output matching a read address, when one exists
  function automatic bit out_for(input logic [4:0] a, output logic [31:0] val);
    val = '0;
    case (a)
      5'd0:  begin val = index_r;   return 1'b1; end
      5'd1:  begin val = random_r;  return 1'b1; end
      5'd2:  begin val = entrylo0;  return 1'b1; end
      5'd3:  begin val = entrylo1;  return 1'b1; end
      5'd4:  begin val = context_r; return 1'b1; end
      5'd5:  begin val = pagemask;  return 1'b1; end
      5'd10: begin val = entryhi;   return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_cmds();
    mtc0_en = 1'b0; tlbp_en = 1'b0; tlbr_en = 1'b0; tlb_exc = 1'b0;
  endtask

  task automatic check_pop();
    sb_t e;
    logic [31:0] o;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".mfc0"}, mfc0_data, e.exp);
    if (e.rs == 3'd0 && out_for(e.ra, o)) chk({e.name, ".out"}, o, e.exp);
  endtask

  // Drive one vector at the negedge, commit at the posedge, check at the next negedge
  task automatic apply(input vec_t t);
    mtc0_en = t.men; mtc0_addr = t.wa; mtc0_sel = t.ws; mtc0_data = t.wd;
    tlbp_en = t.tp; tlbr_en = t.tr; tlb_index_in = t.tidx;
    tlb_entryhi_in = t.tehi; tlb_pagemask_in = t.tpm;
    tlb_entrylo0_in = t.tlo0; tlb_entrylo1_in = t.tlo1;
    tlb_exc = t.ex; exc_badvaddr = t.bva;
    mfc0_addr = t.ra; mfc0_sel = t.rs;
    sb.push_back('{t.name, t.ra, t.rs, t.exp});
    @(posedge clk); #1;
    clear_cmds();
    @(negedge clk);
    check_pop();
  endtask

  task automatic mtc0_once(input logic [4:0] a, input logic [31:0] d);
    mtc0_en = 1'b1; mtc0_addr = a; mtc0_sel = 3'd0; mtc0_data = d;
    @(posedge clk); #1;
    clear_cmds();
    @(negedge clk);
  endtask

  initial begin : main
    logic [31:0] rnd_seq[10];
    logic [31:0] wired3_seq[6];
    rnd_seq    = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd7, 32'd6};
    wired3_seq = '{32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd7};

    resetn = 1'b0;
    clear_cmds();
    mtc0_addr = '0; mtc0_sel = '0; mtc0_data = '0;
    mfc0_addr = 5'd1; mfc0_sel = '0;
    tlb_index_in = '0; tlb_entryhi_in = '0; tlb_pagemask_in = '0;
    tlb_entrylo0_in = '0; tlb_entrylo1_in = '0; exc_badvaddr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.random", random_r, 32'd7);
    chk("rst.random_mfc0", mfc0_data, 32'd7);
    chk("rst.index", index_r, 32'd0);
    chk("rst.entryhi", entryhi, 32'd0);
    chk("rst.context", context_r, 32'd0);
    chk("rst.entrylo0", entrylo0, 32'd0);

    // Free-running Random with Wired = 0
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("rand_free[%0d]", i), random_r, rnd_seq[i]);
      @(negedge clk);
    end
    chk("free.index", index_r, 32'd0);
    chk("free.entryhi", entryhi, 32'd0);

    // Wired = 3: Random restarts at 7 and wraps at 3
    mtc0_en = 1'b1; mtc0_addr = 5'd6; mtc0_sel = 3'd0; mtc0_data = 32'd3;
    @(posedge clk); #1;
    clear_cmds();
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rand_wired3[%0d]", i), random_r, wired3_seq[i]);
      @(negedge clk);
    end

    // Wired = 7: Random holds at the top
    mtc0_once(5'd6, 32'd7);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rand_wired7[%0d]", i), random_r, 32'd7);
      @(negedge clk);
    end

    // Table-driven register vectors (state carries from one entry to the next)
    //             name              men wa     ws    wd            tp tr tidx          tehi          tpm           tlo0          tlo1          ex bva           ra     rs    exp
    vecs.push_back(mk("ehi_mask",     1, 5'd10, 3'd0, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd10, 3'd0, 32'hFFFFE0FF));
    vecs.push_back(mk("idx_mask",     1, 5'd0,  3'd0, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd0,  3'd0, 32'h00000007));
    vecs.push_back(mk("tlbp_miss",    0, 5'd0,  3'd0, 32'h0,        1, 0, 32'h80000000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd0,  3'd0, 32'h80000000));
    vecs.push_back(mk("tlbp_hit",     0, 5'd0,  3'd0, 32'h0,        1, 0, 32'h00000005, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd0,  3'd0, 32'h00000005));
    vecs.push_back(mk("lo0_mask",     1, 5'd2,  3'd0, 32'h12345678, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd2,  3'd0, 32'h02345678));
    vecs.push_back(mk("pm_mask",      1, 5'd5,  3'd0, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd5,  3'd0, 32'h01FFE000));
    vecs.push_back(mk("ctx_ptebase",  1, 5'd4,  3'd0, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd4,  3'd0, 32'hFF800000));
    vecs.push_back(mk("sel_wr_ign",   1, 5'd10, 3'd1, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd10, 3'd0, 32'hFFFFE0FF));
    vecs.push_back(mk("sel_rd_zero",  0, 5'd0,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd10, 3'd1, 32'h00000000));
    vecs.push_back(mk("tlbr_ehi",     0, 5'd0,  3'd0, 32'h0,        0, 1, 32'h0,        32'h123450AB, 32'h00006000, 32'hFFFFFFFF, 32'h00000041, 0, 32'h0,        5'd10, 3'd0, 32'h123440AB));
    vecs.push_back(mk("tlbr_lo0",     0, 5'd0,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd2,  3'd0, 32'h03FFFFFF));
    vecs.push_back(mk("tlbr_pm",      0, 5'd0,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd5,  3'd0, 32'h00006000));
    vecs.push_back(mk("tlbr_lo1",     0, 5'd0,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd3,  3'd0, 32'h00000041));
    vecs.push_back(mk("ehi_asid",     1, 5'd10, 3'd0, 32'h0000005A, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd10, 3'd0, 32'h0000005A));
    vecs.push_back(mk("exc_ehi",      1, 5'd10, 3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1, 32'h87654321, 5'd10, 3'd0, 32'h8765405A));
    vecs.push_back(mk("exc_ctx",      0, 5'd0,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd4,  3'd0, 32'hFFC3B2A0));
    vecs.push_back(mk("tlbp_ovr_mtc0",1, 5'd0,  3'd0, 32'h3,        1, 0, 32'h00000002, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd0,  3'd0, 32'h00000002));
    vecs.push_back(mk("tlbr_ovr_mtc0",1, 5'd3,  3'd0, 32'h0,        0, 1, 32'h0,        32'h00001F33, 32'h0,        32'hAAAAAAAA, 32'h04000003, 0, 32'h0,        5'd3,  3'd0, 32'h00000003));
    vecs.push_back(mk("tlbr_ehi_g",   0, 5'd0,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd10, 3'd0, 32'h00000033));
    vecs.push_back(mk("distinct_idx", 1, 5'd2,  3'd0, 32'h00000055, 1, 0, 32'h00000006, 32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd0,  3'd0, 32'h00000006));
    vecs.push_back(mk("distinct_lo0", 0, 5'd0,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd2,  3'd0, 32'h00000055));
    vecs.push_back(mk("exc_ovr_tlbr", 0, 5'd0,  3'd0, 32'h0,        0, 1, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 32'h00002000, 5'd10, 3'd0, 32'h00002033));
    vecs.push_back(mk("tlbr_pm_exc",  0, 5'd0,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd5,  3'd0, 32'h01FFE000));
    vecs.push_back(mk("exc_ctx2",     0, 5'd0,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd4,  3'd0, 32'hFF800010));
    vecs.push_back(mk("bad_addr",     1, 5'd7,  3'd0, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd7,  3'd0, 32'h00000000));
    vecs.push_back(mk("wired_rd",     1, 5'd6,  3'd0, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd6,  3'd0, 32'h00000007));
    vecs.push_back(mk("random_rd",    0, 5'd0,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd1,  3'd0, 32'h00000007));
    vecs.push_back(mk("random_ro",    1, 5'd1,  3'd0, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 32'h0,        5'd1,  3'd0, 32'h00000007));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset asserted with a write in flight: cleared at once, write discarded
    mtc0_en = 1'b1; mtc0_addr = 5'd10; mtc0_sel = 3'd0; mtc0_data = 32'h12345000;
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst.entryhi_async", entryhi, 32'd0);
    chk("midrst.index_async", index_r, 32'd0);
    chk("midrst.random_async", random_r, 32'd7);
    @(posedge clk); #1;
    chk("midrst.entryhi_edge", entryhi, 32'd0);
    clear_cmds();
    @(negedge clk);
    resetn = 1'b1;
    chk("midrst.release_random", random_r, 32'd7);
    @(negedge clk);
    chk("midrst.first_dec", random_r, 32'd6);

    if (sb.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
